// File: rtl/sa_result_requant_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared widths, element types and FSM state encoding for the systolic-array
// result requantizer (sa_result_requant) and its per-element lane
// (sa_requant_lane).
// -----------------------------------------------------------------------------
package sa_pkg;

   localparam int ACC_W  = 32;   // accumulator element width
   localparam int OUT_W  = 8;    // requantized element width
   localparam int PROD_W = 48;   // exact acc * scale product width

   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [OUT_W-1:0]  q8_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } sa_rq_state_e;

endpackage : sa_pkg

// File: rtl/sa_result_requant_lane.sv
// -----------------------------------------------------------------------------
// sa_requant_lane
// Combinational requantization of one accumulator element to int8:
//   p = acc * scale (exact), optional round-half-up bias, arithmetic right
//   shift, zero-point add at full width, clamp to [-128, 127].
// Ports:
//   i_acc    signed 32-bit accumulator element
//   i_scale  signed SCALE_W multiplier (SCALE_W <= 16 keeps p exact in 48 bits)
//   i_shift  arithmetic right-shift amount
//   i_zp     signed 8-bit zero point
//   o_q8     saturated int8 result
//   o_sat    high when the result was clamped
// -----------------------------------------------------------------------------
module sa_requant_lane
   import sa_pkg::*;
#(
   parameter int SCALE_W = 16,
   parameter int SHIFT_W = 5
) (
   input  acc_t                      i_acc,
   input  logic signed [SCALE_W-1:0] i_scale,
   input  logic        [SHIFT_W-1:0] i_shift,
   input  q8_t                       i_zp,
   output q8_t                       o_q8,
   output logic                      o_sat
);

   // One extra bit so the zero-point add can never wrap.
   localparam int R_W = PROD_W + 1;
   localparam logic signed [R_W-1:0]  Q8_MAX    = {{(R_W-OUT_W){1'b0}}, 8'h7F};
   localparam logic signed [R_W-1:0]  Q8_MIN    = {{(R_W-OUT_W){1'b1}}, 8'h80};
   localparam prod_t                  PROD_ONE  = {{(PROD_W-1){1'b0}}, 1'b1};
   localparam logic [SHIFT_W-1:0]     SHIFT_ONE = {{(SHIFT_W-1){1'b0}}, 1'b1};

   prod_t                 w_prod;
   prod_t                 w_round;
   prod_t                 w_shifted;
   logic signed [R_W-1:0] w_r;

   // Product, rounding bias, shift, zero-point add and saturation
   always_comb begin
      w_prod = prod_t'(i_acc) * prod_t'(i_scale);
      if (i_shift != {SHIFT_W{1'b0}}) begin
         w_round = PROD_ONE << (i_shift - SHIFT_ONE);
      end else begin
         w_round = {PROD_W{1'b0}};
      end
      w_shifted = (w_prod + w_round) >>> i_shift;
      w_r = {w_shifted[PROD_W-1], w_shifted} + {{(R_W-OUT_W){i_zp[OUT_W-1]}}, i_zp};
      if (w_r > Q8_MAX) begin
         o_q8  = 8'sh7F;
         o_sat = 1'b1;
      end else if (w_r < Q8_MIN) begin
         o_q8  = 8'sh80;
         o_sat = 1'b1;
      end else begin
         o_q8  = w_r[OUT_W-1:0];
         o_sat = 1'b0;
      end
   end

endmodule : sa_requant_lane

// File: rtl/sa_result_requant.sv
// -----------------------------------------------------------------------------
// sa_result_requant
// Captures the NxN accumulator matrix from the systolic array on its
// result-valid pulse, requantizes one row at a time to int8 and streams the
// rows over a valid/ready interface. A result arriving while busy is dropped
// and flagged on the sticky o_dropErr.
// Optional build macro: SA_REQUANT_SATCOUNT_EN adds o_satCount, the number of
// clamped elements in accepted rows of the current tile (saturating at 0xFFFF).
// Ports:
//   i_clk, i_arst            clock, synchronous active-high reset
//   i_c                      matrix, element [r][c] at bits (r*N+c)*32 +: 32
//   i_validResult            one-cycle capture strobe for i_c
//   i_scale/i_shift/i_zeroPoint  requant parameters, latched with the matrix
//   o_row                    requantized row, column c at bits c*8 +: 8
//   o_rowIdx, o_last         row number on o_row, high with row N-1
//   o_valid, i_ready         output handshake
//   o_idle                   ready to capture a new matrix
//   o_dropErr                sticky: a result arrived while busy
// -----------------------------------------------------------------------------
module sa_result_requant
   import sa_pkg::*;
#(
   parameter int N       = 4,
   parameter int SCALE_W = 16,
   parameter int SHIFT_W = 5
) (
   input  logic                        i_clk,
   input  logic                        i_arst,
   input  logic signed [N*N*ACC_W-1:0] i_c,
   input  logic                        i_validResult,
   input  logic signed [SCALE_W-1:0]   i_scale,
   input  logic        [SHIFT_W-1:0]   i_shift,
   input  logic signed [OUT_W-1:0]     i_zeroPoint,
   output logic signed [N*OUT_W-1:0]   o_row,
   output logic [$clog2(N)-1:0]        o_rowIdx,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_last,
   output logic                        o_idle,
   output logic                        o_dropErr
`ifdef SA_REQUANT_SATCOUNT_EN
   ,
   output logic [15:0]                 o_satCount
`endif
);

   localparam int IDX_W = $clog2(N);
   // One bit wider than the row index so "all rows loaded" (== N) is representable.
   localparam int PTR_W = $clog2(N) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);
   localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(N);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

   sa_rq_state_e               r_state;
   sa_rq_state_e               w_stateNext;
   acc_t                       r_buf [N][N];
   logic signed [SCALE_W-1:0]  r_scale;
   logic [SHIFT_W-1:0]         r_shift;
   q8_t                        r_zp;
   logic [PTR_W-1:0]           r_rowPtr;
   logic [IDX_W-1:0]           w_rowSel;
   logic signed [N*OUT_W-1:0]  w_rowQ;
   logic [N-1:0]               w_rowSat;
   logic                       w_capture;
   logic                       w_load;
   logic                       w_accept;
   logic                       r_valid;
   logic                       r_last;
   logic                       r_idle;
   logic                       r_dropErr;
   logic [IDX_W-1:0]           r_rowIdx;
   logic signed [N*OUT_W-1:0]  r_row;

   // Next state plus capture/load/accept strobes
   always_comb begin
      w_stateNext = r_state;
      w_capture   = 1'b0;
      w_load      = 1'b0;
      w_accept    = r_valid & i_ready;
      case (r_state)
         IDLE: begin
            if (i_validResult) begin
               w_capture   = 1'b1;
               w_stateNext = STREAM;
            end else begin
               w_stateNext = IDLE;
            end
         end
         STREAM: begin
            // Refill the output register when empty or draining this cycle.
            if ((r_rowPtr != PTR_END) && (!r_valid || w_accept)) begin
               w_load = 1'b1;
            end else begin
               w_load = 1'b0;
            end
            if (w_accept && r_last) begin
               w_stateNext = IDLE;
            end else begin
               w_stateNext = STREAM;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Row select, parked on row 0 once every row has been loaded
   always_comb begin
      if (r_rowPtr < PTR_END) begin
         w_rowSel = r_rowPtr[IDX_W-1:0];
      end else begin
         w_rowSel = {IDX_W{1'b0}};
      end
   end

   for (genvar c = 0; c < N; c++) begin : g_lane
      sa_requant_lane #(
         .SCALE_W (SCALE_W),
         .SHIFT_W (SHIFT_W)
      ) u_lane (
         .i_acc   (r_buf[w_rowSel][c]),
         .i_scale (r_scale),
         .i_shift (r_shift),
         .i_zp    (r_zp),
         .o_q8    (w_rowQ[c*OUT_W +: OUT_W]),
         .o_sat   (w_rowSat[c])
      );
   end

   // Capture buffer and latched parameters (no reset needed: written before use)
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_buf[r][c] <= i_c[(r*N + c)*ACC_W +: ACC_W];
            end
         end
         r_scale <= i_scale;
         r_shift <= i_shift;
         r_zp    <= i_zeroPoint;
      end
   end

   // FSM state, row pointer, output register and sticky drop flag
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state   <= IDLE;
         r_rowPtr  <= {PTR_W{1'b0}};
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_rowIdx  <= {IDX_W{1'b0}};
         r_row     <= {(N*OUT_W){1'b0}};
         r_idle    <= 1'b1;
         r_dropErr <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_idle    <= (w_stateNext == IDLE);
         r_dropErr <= r_dropErr | (i_validResult & (r_state != IDLE));
         if (w_capture) begin
            r_rowPtr <= {PTR_W{1'b0}};
         end else if (w_load) begin
            r_rowPtr <= r_rowPtr + PTR_ONE;
         end
         if (w_load) begin
            r_valid  <= 1'b1;
            r_row    <= w_rowQ;
            r_rowIdx <= w_rowSel;
            r_last   <= (r_rowPtr == PTR_LAST);
         end else if (w_accept) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
         end
      end
   end

`ifdef SA_REQUANT_SATCOUNT_EN
   localparam int CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] w_rowSatCnt;
   logic [CNT_W-1:0] r_rowSatCnt;
   logic [16:0]      w_satSum;
   logic [15:0]      r_satCount;

   // Clamped-element count of the row being loaded and the running sum
   always_comb begin
      w_rowSatCnt = {CNT_W{1'b0}};
      for (int c = 0; c < N; c++) begin
         w_rowSatCnt = w_rowSatCnt + CNT_W'(w_rowSat[c]);
      end
      w_satSum = {1'b0, r_satCount} + 17'(r_rowSatCnt);
   end

   // Per-row count travels with the row; totals are added on handshake
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_rowSatCnt <= {CNT_W{1'b0}};
         r_satCount  <= 16'h0000;
      end else begin
         if (w_load) begin
            r_rowSatCnt <= w_rowSatCnt;
         end
         if (w_capture) begin
            r_satCount <= 16'h0000;
         end else if (w_accept) begin
            r_satCount <= w_satSum[16] ? 16'hFFFF : w_satSum[15:0];
         end
      end
   end

   assign o_satCount = r_satCount;
`else
   // Clamp flags only feed the optional counter; fold them into a sink here.
   logic w_unusedSat;
   assign w_unusedSat = ^w_rowSat;
`endif

   assign o_row     = r_row;
   assign o_rowIdx  = r_rowIdx;
   assign o_valid   = r_valid;
   assign o_last    = r_last;
   assign o_idle    = r_idle;
   assign o_dropErr = r_dropErr;

endmodule : sa_result_requant
